// File: rtl/ad_volt_pkg.sv
// ad_volt_pkg: shared constants and FSM encoding for the AD7606 voltage-to-BCD converter
package ad_volt_pkg;
    localparam logic [7:0] ASCII_PLUS  = 8'd43;
    localparam logic [7:0] ASCII_MINUS = 8'd45;
    localparam int         BCD_MAX     = 99999;
    localparam int         BCD_ITER    = 17;
    typedef enum logic [2:0] {IDLE, ABS, MUL, BCD, STORE, DONE} state_t;
endpackage

// File: rtl/ad_volt_bcd_bin2bcd.sv
// bin2bcd_serial: serial double-dabble converter, 17-bit binary to 5-digit packed BCD
//   clk, reset_n : clock, async active-low reset
//   start        : load bin and begin a 17-iteration conversion
//   bin          : binary value (<= 99999)
//   done         : high during the final iteration; bcd holds the result from the next cycle
//   bcd          : packed BCD result, held until the next start
module bin2bcd_serial
    import ad_volt_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [16:0] bin,
    output logic        done,
    output logic [19:0] bcd
);
    logic [16:0] sh;
    logic [4:0]  cnt;
    logic [19:0] adj;
    for (genvar n = 0; n < 5; n++) begin : g_adj
        assign adj[4*n +: 4] = (bcd[4*n +: 4] >= 4'd5) ? bcd[4*n +: 4] + 4'd3 : bcd[4*n +: 4];
    end
    assign done = (cnt == 5'd1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh  <= '0;
            bcd <= '0;
            cnt <= '0;
        end else if (start) begin
            sh  <= bin;
            bcd <= '0;
            cnt <= 5'(BCD_ITER);
        end else if (cnt != 5'd0) begin
            {bcd, sh} <= {adj[18:0], sh, 1'b0};
            cnt       <= cnt - 5'd1;
        end
    end
endmodule

// File: rtl/ad_volt_bcd.sv
// ad_volt_bcd: converts eight signed AD7606 codes into ASCII sign + X.XXXX V packed-BCD fields
//   clk50, reset_n        : 50 MHz clock, async active-low reset
//   ad_ch1..ad_ch8        : two's-complement codes, latched on ad_data_valid
//   ad_data_valid         : one-cycle pulse, accepted only while idle
//   ch1_dec..ch8_dec      : packed BCD magnitude, [19:16] volts, [15:0] fraction
//   ch1_sig..ch8_sig      : ASCII '+' (43) or '-' (45)
//   conv_done             : one-cycle pulse in the cycle all outputs update
//   busy                  : high from the cycle after capture through the conv_done cycle
module ad_volt_bcd
    import ad_volt_pkg::*;
#(
    parameter int SCALE = 50000,
    parameter int SHIFT = 15
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic [15:0] ad_ch1,
    input  logic [15:0] ad_ch2,
    input  logic [15:0] ad_ch3,
    input  logic [15:0] ad_ch4,
    input  logic [15:0] ad_ch5,
    input  logic [15:0] ad_ch6,
    input  logic [15:0] ad_ch7,
    input  logic [15:0] ad_ch8,
    input  logic        ad_data_valid,
    output logic [19:0] ch1_dec,
    output logic [19:0] ch2_dec,
    output logic [19:0] ch3_dec,
    output logic [19:0] ch4_dec,
    output logic [19:0] ch5_dec,
    output logic [19:0] ch6_dec,
    output logic [19:0] ch7_dec,
    output logic [19:0] ch8_dec,
    output logic [7:0]  ch1_sig,
    output logic [7:0]  ch2_sig,
    output logic [7:0]  ch3_sig,
    output logic [7:0]  ch4_sig,
    output logic [7:0]  ch5_sig,
    output logic [7:0]  ch6_sig,
    output logic [7:0]  ch7_sig,
    output logic [7:0]  ch8_sig,
    output logic        conv_done,
    output logic        busy
);
    state_t      state, nstate;
    logic [2:0]  idx;
    logic [15:0] code_q [8];
    logic [15:0] cur, mag, mag_q;
    logic        neg_q;
    logic [32:0] prod, scaled;
    logic [16:0] val;
    logic        bcd_done;
    logic [19:0] bcd;
    logic [19:0] sh_dec [8], out_dec [8];
    logic [7:0]  sh_sig [8], out_sig [8];
    assign cur    = code_q[idx];
    // -32768 negates to 16'h8000, which read as unsigned is the wanted 32768
    assign mag    = cur[15] ? 16'(-cur) : cur;
    assign prod   = 33'(mag_q) * 33'(SCALE);
    assign scaled = prod >> SHIFT;
    assign val    = (scaled > 33'(BCD_MAX)) ? 17'(BCD_MAX) : scaled[16:0];
    bin2bcd_serial u_bcd (
        .clk     (clk50),
        .reset_n (reset_n),
        .start   (state == MUL),
        .bin     (val),
        .done    (bcd_done),
        .bcd     (bcd)
    );
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = ad_data_valid ? ABS : IDLE;
            ABS:     nstate = MUL;
            MUL:     nstate = BCD;
            BCD:     nstate = bcd_done ? STORE : BCD;
            STORE:   nstate = (idx == 3'd7) ? DONE : ABS;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            neg_q     <= 1'b0;
            mag_q     <= '0;
            conv_done <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                code_q[i]  <= '0;
                sh_dec[i]  <= '0;
                sh_sig[i]  <= ASCII_PLUS;
                out_dec[i] <= '0;
                out_sig[i] <= ASCII_PLUS;
            end
        end else begin
            state     <= nstate;
            conv_done <= (state == DONE);
            // lags the FSM by one cycle so it stays high through the conv_done cycle
            busy      <= (state != IDLE);
            if (state == IDLE && ad_data_valid) begin
                code_q <= '{ad_ch1, ad_ch2, ad_ch3, ad_ch4, ad_ch5, ad_ch6, ad_ch7, ad_ch8};
                idx    <= '0;
            end
            if (state == ABS) begin
                neg_q <= cur[15];
                mag_q <= mag;
            end
            if (state == STORE) begin
                sh_sig[idx] <= neg_q ? ASCII_MINUS : ASCII_PLUS;
                sh_dec[idx] <= bcd;
                idx         <= idx + 3'd1;
            end
            if (state == DONE) begin
                out_dec <= sh_dec;
                out_sig <= sh_sig;
            end
        end
    end
    assign ch1_dec = out_dec[0];
    assign ch2_dec = out_dec[1];
    assign ch3_dec = out_dec[2];
    assign ch4_dec = out_dec[3];
    assign ch5_dec = out_dec[4];
    assign ch6_dec = out_dec[5];
    assign ch7_dec = out_dec[6];
    assign ch8_dec = out_dec[7];
    assign ch1_sig = out_sig[0];
    assign ch2_sig = out_sig[1];
    assign ch3_sig = out_sig[2];
    assign ch4_sig = out_sig[3];
    assign ch5_sig = out_sig[4];
    assign ch6_sig = out_sig[5];
    assign ch7_sig = out_sig[6];
    assign ch8_sig = out_sig[7];
endmodule
